fmdll_lock_monitor: RTL and testbench
=====================================

Name: fmdll_lock_monitor

Overview:
- Lock detector and code monitor for the frequency-multiplying DLL.
- Reads the delay-control code that the phase/tap controller writes to the delay line, one update per code_vld strobe.
- Declares lock when the code settles, declares loss of lock when it drifts, and flags acquisition timeout.
- Runs in the reference clock domain. Its outputs drive system-level status and the relock request.

Parameters:
- CODE_W, 10: width of the delay-control code.
- TOL, 2: maximum |code - reference| still counted as stable, in LSBs.
- LOCK_CNT, 16: consecutive in-tolerance updates required to declare lock.
- UNLOCK_CNT, 4: consecutive out-of-tolerance updates in LOCKED before declaring lock lost.
- TIMEOUT, 1023: maximum code_vld updates allowed in ACQ before FAIL.

Ports:
- CLK_exit, input, 1: reference clock; sole clock.
- rst, input, 1: asynchronous active-high reset.
- en, input, 1: monitor enable.
- M, input, 2: multiplier configuration, same value as given to the DLL.
- N, input, 4: multiplier configuration, same value as given to the DLL.
- code_vld, input, 1: one-cycle strobe; code is valid this cycle.
- code, input, CODE_W: current delay-control code.
- lock, output, 1: DLL locked.
- lock_lost, output, 1: one-cycle pulse on a LOCKED->ACQ drift exit.
- fail, output, 1: acquisition timeout; held high while in FAIL.
- relock_req, output, 1: one-cycle pulse on every entry to ACQ.
- code_locked, output, CODE_W: code captured at lock.
- state, output, 2: IDLE=0, ACQ=1, LOCKED=2, FAIL=3.

Behaviour:
- Interface: one clock, CLK_exit. Reset rst is asynchronous, active-high. All state updates on the rising edge of CLK_exit.
- Reset values:
  - state=IDLE.
  - lock=0, lock_lost=0, fail=0, relock_req=0, code_locked=0.
  - Internal ref=0, stable_cnt=0, miss_cnt=0, tmo_cnt=0, first=1.
  - M_q/N_q = 0.
- Registers M_q and N_q capture M and N every cycle. cfg_chg = (M != M_q) || (N != N_q).
- Event priority per cycle, highest first: en=0, then cfg_chg, then code_vld.
- en=0 in any state:
  - Next cycle state=IDLE.
  - lock=0, fail=0; all counters cleared; first=1.
  - code_locked holds its value.
- IDLE, en=1: go to ACQ. relock_req pulses in the same cycle the state becomes ACQ.
- cfg_chg in ACQ or LOCKED:
  - Go to ACQ; counters cleared; first=1; lock=0.
  - relock_req pulses; no lock_lost pulse.
- ACQ, on code_vld:
  - If first: ref<=code, stable_cnt<=0, first<=0.
  - Otherwise d = |code - ref|, computed unsigned in CODE_W+1 bits with no wrap (0 vs 1023 gives d=1023).
  - If d <= TOL: stable_cnt++. Otherwise ref<=code and stable_cnt<=0.
  - tmo_cnt++ on every code_vld.
- ACQ -> LOCKED: when an in-tolerance update brings stable_cnt to LOCK_CNT.
  - lock=1 on the first cycle of LOCKED (registered, 1-cycle latency from the strobe).
  - code_locked<=ref; miss_cnt<=0.
- ACQ -> FAIL: when tmo_cnt reaches TIMEOUT and the lock condition is not met in the same update. Lock wins a tie. fail=1.
- LOCKED, on code_vld:
  - d computed against code_locked.
  - d > TOL: miss_cnt++. d <= TOL: miss_cnt<=0.
  - code_locked is not tracked or updated.
- LOCKED -> ACQ: when miss_cnt reaches UNLOCK_CNT.
  - lock=0; lock_lost and relock_req pulse for one cycle.
  - ref<=code, first<=0, stable_cnt<=0, tmo_cnt<=0.
- FAIL is terminal until en=0. It ignores code_vld and cfg_chg.
- Counters saturate and never wrap. Widths: clog2(LOCK_CNT+1), clog2(UNLOCK_CNT+1), clog2(TIMEOUT+1).
- code_vld while in IDLE or FAIL is ignored.
- Asserting rst mid-operation returns all outputs to their reset values immediately.

Decomposition:
- Shared package fmdll_pkg holds:
  - State encodings ST_IDLE, ST_ACQ, ST_LOCKED, ST_FAIL.
  - Default CODE_W, also used by the tap controller and delay line.
- One sub-module, fmdll_absdiff: combinational |a-b| for CODE_W bits, instantiated once.
- Counters and FSM stay in the top module.

Test Plan:
- Lock acquisition: en=1, then 16 code_vld with codes alternating 300/302 -> lock=1 one cycle after the 17th strobe (1 load + 16 stable), code_locked=300, state=2; relock_req pulsed once at entry to ACQ.
- Drift loss: from lock on code_locked=300, send 3×code=310 then 1×301 then 4×310 -> lock stays 1 through the first five updates; lock_lost pulses once after the 8th update; state=1, ref=310.
- Timeout: TIMEOUT=20, codes toggling 100/200 -> fail=1, state=3 after the 20th update. Further codes are ignored; en=0 -> state=0, fail=0 next cycle.
- Config change: while locked, change N 4->6 -> next cycle lock=0, state=1, relock_req=1, lock_lost=0. Relock then requires a fresh 17 updates.
- Boundary: codes 0 and 1023 alternating -> never in tolerance, no wrap to d=1. Codes 1022/1023/1021 -> counted stable.
- Reset mid-LOCKED: assert rst asynchronously between edges -> lock, state and code_locked are 0 immediately; after release with en=1 -> ACQ.

Source files
------------

// File: rtl/fmdll_pkg.sv
// Shared definitions for the frequency-multiplying DLL blocks.
// Holds the lock-monitor state encoding and the default delay-control code
// width. The tap controller and the delay line use the same code width.
package fmdll_pkg;

  localparam int FMDLL_CODE_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } fmdll_state_e;

endpackage

// File: rtl/fmdll_absdiff.sv
// Combinational absolute difference |i_a - i_b| of two unsigned codes.
// The larger operand is always the minuend, so the result cannot wrap.
// For example, 0 vs 1023 gives 1023.
// Ports:
//   i_a, i_b : W-bit unsigned operands
//   o_diff   : W-bit unsigned magnitude of the difference
module fmdll_absdiff #(
  parameter int W = 10
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff
);

  assign o_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);

endmodule

// File: rtl/fmdll_lock_monitor.sv
// Lock detector and code monitor for the frequency-multiplying DLL.
// Watches the delay-control code on every code_vld strobe. It declares lock
// when the code settles and loss of lock when the code drifts. It flags a
// timeout if acquisition takes too many updates.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | monitor disabled (en=0) or just out of reset
// ACQ   | tracking a reference code, counting consecutive stable updates
// LOCKED| lock declared; watching for drift against code_locked
// FAIL  | acquisition timed out; held until en=0
//
// Ports:
//   CLK_exit    : reference clock (sole clock)
//   rst         : asynchronous active-high reset
//   en          : monitor enable
//   M, N        : multiplier configuration; any change forces reacquisition
//   code_vld    : one-cycle strobe qualifying code
//   code        : current delay-control code
//   lock        : DLL locked
//   lock_lost   : one-cycle pulse on a drift exit from LOCKED
//   fail        : acquisition timeout, high while in FAIL
//   relock_req  : one-cycle pulse on every entry to ACQ
//   code_locked : reference code captured at lock
//   state       : current FSM state (IDLE=0, ACQ=1, LOCKED=2, FAIL=3)
module fmdll_lock_monitor
  import fmdll_pkg::*;
#(
  parameter int CODE_W     = FMDLL_CODE_W,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              CLK_exit,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        M,
  input  logic [3:0]        N,
  input  logic              code_vld,
  input  logic [CODE_W-1:0] code,
  output logic              lock,
  output logic              lock_lost,
  output logic              fail,
  output logic              relock_req,
  output logic [CODE_W-1:0] code_locked,
  output logic [1:0]        state
);

  localparam int STB_W = $clog2(LOCK_CNT + 1);
  localparam int MIS_W = $clog2(UNLOCK_CNT + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [STB_W-1:0]  STB_MAX = STB_W'(LOCK_CNT);
  localparam logic [MIS_W-1:0]  MIS_MAX = MIS_W'(UNLOCK_CNT);
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT);
  localparam logic [CODE_W-1:0] TOL_C   = CODE_W'(TOL);

  fmdll_state_e      r_state, w_nxt_state;
  logic [CODE_W-1:0] r_ref, w_nxt_ref;
  logic [CODE_W-1:0] r_code_locked, w_nxt_code_locked;
  logic [STB_W-1:0]  r_stable, w_nxt_stable;
  logic [MIS_W-1:0]  r_miss, w_nxt_miss;
  logic [TMO_W-1:0]  r_tmo, w_nxt_tmo;
  logic              r_first, w_nxt_first;
  logic              r_lock_lost, w_nxt_lock_lost;
  logic              r_relock, w_nxt_relock;
  logic [1:0]        r_m_q;
  logic [3:0]        r_n_q;

  logic              w_cfg_chg;
  logic [CODE_W-1:0] w_cmp_ref;
  logic [CODE_W-1:0] w_diff;
  logic              w_in_tol;
  logic [STB_W-1:0]  w_stable_inc;
  logic [MIS_W-1:0]  w_miss_inc;
  logic [TMO_W-1:0]  w_tmo_inc;

  assign w_cfg_chg = (M != r_m_q) || (N != r_n_q);

  // One subtractor serves both states.
  // ACQ compares against the running reference.
  // LOCKED compares against the code frozen at lock.
  assign w_cmp_ref = (r_state == ST_LOCKED) ? r_code_locked : r_ref;

  fmdll_absdiff #(.W(CODE_W)) u_absdiff (
    .i_a    (code),
    .i_b    (w_cmp_ref),
    .o_diff (w_diff)
  );

  assign w_in_tol = (w_diff <= TOL_C);

  // Saturating increments; the counters never wrap.
  assign w_stable_inc = (r_stable == STB_MAX) ? r_stable : r_stable + 1'b1;
  assign w_miss_inc   = (r_miss   == MIS_MAX) ? r_miss   : r_miss   + 1'b1;
  assign w_tmo_inc    = (r_tmo    == TMO_MAX) ? r_tmo    : r_tmo    + 1'b1;

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_ref         = r_ref;
    w_nxt_code_locked = r_code_locked;
    w_nxt_stable      = r_stable;
    w_nxt_miss        = r_miss;
    w_nxt_tmo         = r_tmo;
    w_nxt_first       = r_first;
    w_nxt_lock_lost   = 1'b0;
    w_nxt_relock      = 1'b0;

    if (!en) begin
      w_nxt_state  = ST_IDLE;
      w_nxt_stable = '0;
      w_nxt_miss   = '0;
      w_nxt_tmo    = '0;
      w_nxt_first  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nxt_state  = ST_ACQ;
          w_nxt_relock = 1'b1;
        end

        ST_ACQ: begin
          if (w_cfg_chg) begin
            w_nxt_stable = '0;
            w_nxt_miss   = '0;
            w_nxt_tmo    = '0;
            w_nxt_first  = 1'b1;
            w_nxt_relock = 1'b1;
          end else if (code_vld) begin
            w_nxt_tmo = w_tmo_inc;
            if (r_first) begin
              w_nxt_ref    = code;
              w_nxt_stable = '0;
              w_nxt_first  = 1'b0;
            end else if (w_in_tol) begin
              w_nxt_stable = w_stable_inc;
              if (w_stable_inc == STB_MAX) begin
                w_nxt_state       = ST_LOCKED;
                w_nxt_code_locked = r_ref;
                w_nxt_miss        = '0;
              end
            end else begin
              w_nxt_ref    = code;
              w_nxt_stable = '0;
            end
            // Lock takes precedence when both thresholds are hit together.
            if ((w_nxt_state == ST_ACQ) && (w_tmo_inc == TMO_MAX)) begin
              w_nxt_state = ST_FAIL;
            end
          end
        end

        ST_LOCKED: begin
          if (w_cfg_chg) begin
            w_nxt_state  = ST_ACQ;
            w_nxt_stable = '0;
            w_nxt_miss   = '0;
            w_nxt_tmo    = '0;
            w_nxt_first  = 1'b1;
            w_nxt_relock = 1'b1;
          end else if (code_vld) begin
            if (w_in_tol) begin
              w_nxt_miss = '0;
            end else begin
              w_nxt_miss = w_miss_inc;
              if (w_miss_inc == MIS_MAX) begin
                // The drifted code becomes the new reference.
                // The next update can therefore already count as stable.
                w_nxt_state     = ST_ACQ;
                w_nxt_ref       = code;
                w_nxt_first     = 1'b0;
                w_nxt_stable    = '0;
                w_nxt_tmo       = '0;
                w_nxt_miss      = '0;
                w_nxt_lock_lost = 1'b1;
                w_nxt_relock    = 1'b1;
              end
            end
          end
        end

        ST_FAIL: begin
          w_nxt_state = ST_FAIL;
        end

        default: begin
          w_nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_exit or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ref         <= '0;
      r_code_locked <= '0;
      r_stable      <= '0;
      r_miss        <= '0;
      r_tmo         <= '0;
      r_first       <= 1'b1;
      r_lock_lost   <= 1'b0;
      r_relock      <= 1'b0;
      r_m_q         <= '0;
      r_n_q         <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_ref         <= w_nxt_ref;
      r_code_locked <= w_nxt_code_locked;
      r_stable      <= w_nxt_stable;
      r_miss        <= w_nxt_miss;
      r_tmo         <= w_nxt_tmo;
      r_first       <= w_nxt_first;
      r_lock_lost   <= w_nxt_lock_lost;
      r_relock      <= w_nxt_relock;
      r_m_q         <= M;
      r_n_q         <= N;
    end
  end

  assign lock        = (r_state == ST_LOCKED);
  assign fail        = (r_state == ST_FAIL);
  assign lock_lost   = r_lock_lost;
  assign relock_req  = r_relock;
  assign code_locked = r_code_locked;
  assign state       = r_state;

endmodule

// File: tb/tb_fmdll_lock_monitor.sv
module tb_fmdll_lock_monitor;

  localparam int CW   = 10;
  localparam int TOLV = 2;
  localparam int LCK  = 16;
  localparam int ULK  = 4;
  localparam int TMO  = 20;

  localparam int S_IDLE = 0, S_ACQ = 1, S_LOCKED = 2, S_FAIL = 3;

  logic          CLK_exit = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    M = 2'd1;
  logic [3:0]    N = 4'd4;
  logic          code_vld = 1'b0;
  logic [CW-1:0] code = '0;
  logic          lock, lock_lost, fail, relock_req;
  logic [CW-1:0] code_locked;
  logic [1:0]    state;

  int n_tests = 0;
  int n_fail  = 0;

  fmdll_lock_monitor #(
    .CODE_W(CW), .TOL(TOLV), .LOCK_CNT(LCK), .UNLOCK_CNT(ULK), .TIMEOUT(TMO)
  ) dut (
    .CLK_exit(CLK_exit), .rst(rst), .en(en), .M(M), .N(N),
    .code_vld(code_vld), .code(code),
    .lock(lock), .lock_lost(lock_lost), .fail(fail), .relock_req(relock_req),
    .code_locked(code_locked), .state(state)
  );

  always #5 CLK_exit = ~CLK_exit;

  // Behavioural reference: plain integers, evaluated once per rising edge.
  int m_state = S_IDLE, m_ref = 0, m_cl = 0, m_stable = 0, m_miss = 0, m_tmo = 0;
  int m_mq = 0, m_nq = 0, m_d = 0;
  bit m_first = 1'b1, m_lost = 1'b0, m_relock = 1'b0, m_cfg = 1'b0;

  function automatic int absdist(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  always @(posedge CLK_exit or posedge rst) begin
    if (rst) begin
      m_state = S_IDLE; m_ref = 0; m_cl = 0; m_stable = 0; m_miss = 0; m_tmo = 0;
      m_mq = 0; m_nq = 0; m_first = 1'b1; m_lost = 1'b0; m_relock = 1'b0;
    end else begin
      m_cfg = (int'(M) != m_mq) || (int'(N) != m_nq);
      m_mq = int'(M);
      m_nq = int'(N);
      m_lost = 1'b0;
      m_relock = 1'b0;
      if (!en) begin
        m_state = S_IDLE; m_stable = 0; m_miss = 0; m_tmo = 0; m_first = 1'b1;
      end else if (m_state == S_IDLE) begin
        m_state = S_ACQ; m_relock = 1'b1;
      end else if (m_state != S_FAIL && m_cfg) begin
        m_state = S_ACQ; m_stable = 0; m_miss = 0; m_tmo = 0; m_first = 1'b1;
        m_relock = 1'b1;
      end else if (code_vld && m_state == S_ACQ) begin
        m_tmo = m_tmo + 1;
        if (m_first) begin
          m_ref = int'(code); m_stable = 0; m_first = 1'b0;
        end else begin
          m_d = absdist(int'(code), m_ref);
          if (m_d <= TOLV) m_stable = m_stable + 1;
          else begin m_ref = int'(code); m_stable = 0; end
        end
        if (m_stable == LCK) begin
          m_state = S_LOCKED; m_cl = m_ref; m_miss = 0;
        end else if (m_tmo >= TMO) begin
          m_state = S_FAIL;
        end
      end else if (code_vld && m_state == S_LOCKED) begin
        m_d = absdist(int'(code), m_cl);
        if (m_d > TOLV) m_miss = m_miss + 1;
        else m_miss = 0;
        if (m_miss == ULK) begin
          m_state = S_ACQ; m_lost = 1'b1; m_relock = 1'b1;
          m_ref = int'(code); m_first = 1'b0; m_stable = 0; m_tmo = 0; m_miss = 0;
        end
      end
    end
  end

  // Compare every cycle, half a period after the active edge.
  always @(negedge CLK_exit) begin
    n_tests++;
    if (lock !== (m_state == S_LOCKED) || fail !== (m_state == S_FAIL) ||
        lock_lost !== m_lost || relock_req !== m_relock ||
        code_locked !== CW'(m_cl) || state !== 2'(m_state)) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t: got st=%0d lk=%0b ll=%0b fl=%0b rr=%0b cl=%0d, want st=%0d lk=%0b ll=%0b fl=%0b rr=%0b cl=%0d",
               $time, state, lock, lock_lost, fail, relock_req, code_locked,
               m_state, (m_state == S_LOCKED), m_lost, (m_state == S_FAIL), m_relock, m_cl);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then move on to the next falling edge.
  task automatic step(input logic v, input int c);
    code_vld = v;
    code = CW'(c);
    @(negedge CLK_exit);
  endtask

  task automatic restart();
    en = 1'b0;
    step(1'b0, 0);
    en = 1'b1;
    step(1'b0, 0);
  endtask

  int seq3[3] = '{1022, 1023, 1021};
  int center;
  int rc;

  initial begin
    @(negedge CLK_exit);
    chk("reset_state", int'(state), 0);
    chk("reset_lock", int'(lock), 0);
    chk("reset_code_locked", int'(code_locked), 0);
    rst = 1'b0;
    en = 1'b1;
    step(1'b0, 0);
    chk("enter_acq_state", int'(state), 1);
    chk("enter_acq_relock", int'(relock_req), 1);

    // Lock acquisition: 1 load plus 16 stable updates.
    for (int i = 0; i < 17; i++) begin
      step(1'b1, (i % 2 == 0) ? 300 : 302);
      if (i == 15) chk("acq_lock_after16", int'(lock), 0);
    end
    chk("acq_lock", int'(lock), 1);
    chk("acq_code_locked", int'(code_locked), 300);
    chk("acq_state", int'(state), 2);

    // Drift loss.
    step(1'b1, 310); step(1'b1, 310); step(1'b1, 310); step(1'b1, 301);
    step(1'b1, 310); step(1'b1, 310); step(1'b1, 310);
    chk("drift_lock_held", int'(lock), 1);
    chk("drift_no_lost_yet", int'(lock_lost), 0);
    step(1'b1, 310);
    chk("drift_lost_pulse", int'(lock_lost), 1);
    chk("drift_relock_pulse", int'(relock_req), 1);
    chk("drift_state", int'(state), 1);
    step(1'b0, 0);
    chk("drift_lost_one_cycle", int'(lock_lost), 0);
    // The reference is now 310 with no load pending, so 16 updates relock.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 310);
      if (i == 14) chk("drift_relock_after15", int'(lock), 0);
    end
    chk("drift_relock", int'(lock), 1);
    chk("drift_relock_code", int'(code_locked), 310);

    // Config change while locked.
    N = 4'd6;
    step(1'b0, 0);
    chk("cfg_lock", int'(lock), 0);
    chk("cfg_state", int'(state), 1);
    chk("cfg_relock", int'(relock_req), 1);
    chk("cfg_no_lost", int'(lock_lost), 0);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 500);
      if (i == 15) chk("cfg_after16", int'(lock), 0);
    end
    chk("cfg_relocked", int'(lock), 1);

    // Boundary: 0 vs 1023 must not wrap into tolerance.
    restart();
    for (int i = 0; i < 10; i++) step(1'b1, (i % 2 == 0) ? 0 : 1023);
    chk("wrap_state", int'(state), 1);
    restart();
    for (int i = 0; i < 17; i++) step(1'b1, seq3[i % 3]);
    chk("near_max_lock", int'(lock), 1);
    chk("near_max_code", int'(code_locked), 1022);

    // Lock and timeout land on the same update: lock wins.
    restart();
    step(1'b1, 100); step(1'b1, 200); step(1'b1, 100); step(1'b1, 300);
    for (int i = 0; i < 16; i++) step(1'b1, 300);
    chk("tie_state", int'(state), 2);
    chk("tie_fail", int'(fail), 0);

    // Timeout.
    restart();
    for (int i = 0; i < TMO; i++) begin
      step(1'b1, (i % 2 == 0) ? 100 : 200);
      if (i == TMO - 2) chk("tmo_before", int'(state), 1);
    end
    chk("tmo_state", int'(state), 3);
    chk("tmo_fail", int'(fail), 1);
    for (int i = 0; i < 5; i++) step(1'b1, 100);
    N = 4'd2;
    step(1'b0, 0);
    chk("tmo_sticky", int'(state), 3);
    en = 1'b0;
    step(1'b0, 0);
    chk("tmo_exit_state", int'(state), 0);
    chk("tmo_exit_fail", int'(fail), 0);

    // Reset between edges while locked.
    en = 1'b1;
    step(1'b0, 0);
    for (int i = 0; i < 17; i++) step(1'b1, 700);
    chk("prerst_lock", int'(lock), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_lock", int'(lock), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_code_locked", int'(code_locked), 0);
    @(negedge CLK_exit);
    rst = 1'b0;
    step(1'b0, 0);
    chk("rst_release_acq", int'(state), 1);

    // Randomized traffic checked against the model every cycle.
    center = 400;
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 149) == 0) N = N + 4'd1;
      if ($urandom_range(0, 299) == 0) M = M + 2'd1;
      if ($urandom_range(0, 59) == 0) center = $urandom_range(0, 1021);
      if ($urandom_range(0, 24) == 0) rc = $urandom_range(0, 1023);
      else rc = center + $urandom_range(0, 2);
      step(1'($urandom_range(0, 1)), rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
